// File: rtl/jelly3_jfive_divider.sv
// rtl/jelly3_jfive_divider.sv - RV32M radix-2 restoring divide unit with valid/ready handshakes
module jelly3_jfive_divider #(
    parameter int XLEN    = 32,
    parameter int ID_BITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cke,
    input  logic [ID_BITS-1:0] s_id,
    input  logic [1:0]         s_op,
    input  logic [XLEN-1:0]    s_rs1_val,
    input  logic [XLEN-1:0]    s_rs2_val,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [ID_BITS-1:0] m_id,
    output logic [XLEN-1:0]    m_rd_val,
    output logic               m_valid,
    input  logic               m_ready
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t             state_q;
    logic [ID_BITS-1:0] id_q;
    logic               rem_sel_q;
    logic               qneg_q;
    logic               rneg_q;
    logic [XLEN-1:0]    dvd_q;
    logic [XLEN-1:0]    dvs_q;
    logic [XLEN-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    m_rd_val_q;
    logic               m_valid_q;

    logic               s_signed;
    logic               rs1_neg;
    logic               rs2_neg;
    logic [XLEN-1:0]    rs1_abs;
    logic [XLEN-1:0]    rs2_abs;
    logic               div_zero;
    logic               overflow;
    logic [XLEN-1:0]    special_val;

    logic [XLEN:0]      rem_shift_d;
    logic [XLEN:0]      diff_d;
    logic               qbit_d;
    logic [XLEN-1:0]    rem_d;
    logic [XLEN-1:0]    dvd_d;
    logic [XLEN-1:0]    result_d;

    // Operand conditioning on the request side; only consumed on the accept edge.
    always_comb begin
        s_signed    = ~s_op[0];
        rs1_neg     = s_signed & s_rs1_val[XLEN-1];
        rs2_neg     = s_signed & s_rs2_val[XLEN-1];
        rs1_abs     = rs1_neg ? -s_rs1_val : s_rs1_val;
        rs2_abs     = rs2_neg ? -s_rs2_val : s_rs2_val;
        div_zero    = (s_rs2_val == '0);
        overflow    = s_signed && (s_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (s_rs2_val == '1);
        special_val = '0;
        if (div_zero) begin
            special_val = s_op[1] ? s_rs1_val : '1;
        end else begin
            special_val = s_op[1] ? '0 : s_rs1_val;
        end
    end

    // One restoring step; the XLEN+1-bit subtract keeps the carry of the shifted remainder.
    always_comb begin
        rem_shift_d = {rem_q, dvd_q[XLEN-1]};
        diff_d      = rem_shift_d - {1'b0, dvs_q};
        qbit_d      = ~diff_d[XLEN];
        rem_d       = qbit_d ? diff_d[XLEN-1:0] : rem_shift_d[XLEN-1:0];
        dvd_d       = {dvd_q[XLEN-2:0], qbit_d};
        result_d    = rem_sel_q ? (rneg_q ? -rem_d : rem_d)
                                : (qneg_q ? -dvd_d : dvd_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            id_q       <= '0;
            rem_sel_q  <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            m_rd_val_q <= '0;
            m_valid_q  <= 1'b0;
        end else if (cke) begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        id_q      <= s_id;
                        rem_sel_q <= s_op[1];
                        qneg_q    <= rs1_neg ^ rs2_neg;
                        rneg_q    <= rs1_neg;
                        dvd_q     <= rs1_abs;
                        dvs_q     <= rs2_abs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (div_zero || overflow) begin
                            m_rd_val_q <= special_val;
                            m_valid_q  <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            state_q    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        m_rd_val_q <= result_d;
                        m_valid_q  <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready  = cke && (state_q == ST_IDLE);
    assign m_id     = id_q;
    assign m_rd_val = m_rd_val_q;
    assign m_valid  = m_valid_q;

endmodule
